ma_lsu: RTL and testbench

- Memory-access-stage load/store unit. It is the consumer end of the EX-MA pipeline register: it receives the access fields the execute stage produces (valid, read/write enables, address, store data, size, unsigned flag).
- Drives a request/grant/rvalid data bus.
- Generates byte enables and store-data lane replication, and extracts and extends load data.
- Stalls the pipeline while an access is outstanding.

---
 rtl/ma_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_ma_lsu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_lsu.sv
// ma_lsu: memory-access-stage load/store unit.
// Takes the access fields from the EX-MA pipeline register and runs one
// request/grant/rvalid bus transaction for each aligned load or store.
// Store data is replicated across byte lanes. Load data is shifted down and
// then sign- or zero-extended. The upstream pipeline is stalled until the
// access completes.
//
// Ports:
//   clk, rst_ni              clock (rising edge), asynchronous active-low reset
//   valid_i, rd_en_i, wr_en_i access qualifiers from EX-MA (store wins if both)
//   addr_i, wdata_i          byte address and store data
//   size_i, ld_unsigned_i    0=byte 1=half 2=word 3=illegal; zero-extend loads
//   dbus_*_o / dbus_*_i      data bus request side and grant/response side
//   stall_o                  hold upstream pipeline registers
//   load_data_o              extended load result (held until next capture)
//   load_valid_o             one-cycle pulse when a load completes
//   misalign_o               one-cycle pulse when an access is rejected
//   bus_err_o                one-cycle pulse when an access timed out
module ma_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        ld_unsigned_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [1:0]       off_q, off_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic             err_q, err_d;

    logic             access;
    logic             misaligned;
    logic             timeout;
    logic [3:0]       be_new;
    logic [31:0]      wdata_new;

    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (size)
            2'd0:    extend_load = {{24{~uns & s[7]}}, s[7:0]};
            2'd1:    extend_load = {{16{~uns & s[15]}}, s[15:0]};
            default: extend_load = rdata;
        endcase
    endfunction

    always_comb begin
        access     = valid_i && (rd_en_i || wr_en_i);
        misaligned = (size_i == 2'd3) ||
                     (size_i == 2'd1 && addr_i[0]) ||
                     (size_i == 2'd2 && addr_i[1:0] != 2'b00);
        timeout    = (cnt_q == CNT_LAST);
        case (size_i)
            2'd0:    be_new = 4'b0001 << addr_i[1:0];
            2'd1:    be_new = 4'b0011 << {addr_i[1], 1'b0};
            default: be_new = 4'b1111;
        endcase
        case (size_i)
            2'd0:    wdata_new = {4{wdata_i[7:0]}};
            2'd1:    wdata_new = {2{wdata_i[15:0]}};
            default: wdata_new = wdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        uns_d     = uns_q;
        ld_data_d = ld_data_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (access && !misaligned) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    we_d    = wr_en_i;
                    waddr_d = addr_i[31:2];
                    off_d   = addr_i[1:0];
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    size_d  = size_i;
                    uns_d   = ld_unsigned_i;
                end
            end
            ST_REQ: begin
                if (dbus_gnt_i) begin
                    state_d = we_q ? ST_DONE : ST_RDATA;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RDATA: begin
                if (dbus_rvalid_i) begin
                    state_d   = ST_DONE;
                    ld_data_d = extend_load(dbus_rdata_i, off_q, size_q, uns_q);
                end else if (timeout) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    ld_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // The inputs still describe the finished instruction here,
                // so never accept from DONE.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            off_q     <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            ld_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            off_q     <= off_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            ld_data_q <= ld_data_d;
            err_q     <= err_d;
        end
    end

    // stall_o and misalign_o depend combinationally on the inputs, so they
    // are gated with rst_ni to keep every output low while reset is held.
    always_comb begin
        dbus_req_o   = (state_q == ST_REQ);
        dbus_we_o    = we_q;
        dbus_addr_o  = {waddr_q, 2'b00};
        dbus_be_o    = be_q;
        dbus_wdata_o = wdata_q;
        load_data_o  = ld_data_q;
        load_valid_o = (state_q == ST_DONE) && !we_q && !err_q;
        bus_err_o    = (state_q == ST_DONE) && err_q;
        misalign_o   = rst_ni && (state_q == ST_IDLE) && access && misaligned;
        stall_o      = rst_ni && (((state_q == ST_IDLE) && access && !misaligned) ||
                                  (state_q == ST_REQ) || (state_q == ST_RDATA));
    end

endmodule

// File: tb/tb_ma_lsu.sv
module tb_ma_lsu;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid_i, rd_en_i, wr_en_i, ld_unsigned_i;
    logic [31:0] addr_i, wdata_i;
    logic [1:0]  size_i;
    logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic [3:0]  dbus_be_o;
    logic        stall_o, load_valid_o, misalign_o, bus_err_o;
    logic [31:0] load_data_o;

    ma_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .valid_i(valid_i), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i),
        .ld_unsigned_i(ld_unsigned_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i(dbus_rdata_i),
        .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req, stall, mis, lv, err, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          req_cnt = 0;
    logic [31:0] m_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Reference model: lane arithmetic straight from the access rules.
    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        int o;
        o = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << o);
        if (sz == 2'd1) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input logic uns);
        logic [31:0] s, v;
        s = rd >> (8 * int'(a % 4));
        if (sz == 2'd0) begin
            v = s & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = s & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    // Single compare process: one expected record per cycle, checked mid-cycle.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (dbus_req_o === 1'b1) req_cnt++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk1("req", dbus_req_o, e.req);
            chk1("stall", stall_o, e.stall);
            chk1("misalign", misalign_o, e.mis);
            chk1("load_valid", load_valid_o, e.lv);
            chk1("bus_err", bus_err_o, e.err);
            chk("load_data", load_data_o, e.ld);
            if (e.req) begin
                chk1("we", dbus_we_o, e.we);
                chk("addr", dbus_addr_o, e.addr);
                chk("be", {28'b0, dbus_be_o}, {28'b0, e.be});
                chk("wdata", dbus_wdata_o, e.wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_e(input logic req, stall, mis, lv, err, we,
                          input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        e.req = req; e.stall = stall; e.mis = mis; e.lv = lv; e.err = err; e.we = we;
        e.addr = a; e.be = be; e.wdata = wd; e.ld = m_ld;
        q.push_back(e);
    endtask

    task automatic idle_cycle();
        tick();
        valid_i = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        push_e(0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    // gnt_at / rv_at: index of the REQ / RDATA cycle carrying the response (-1 = never)
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                             input int gnt_at, input int rv_at, input logic [31:0] rdata);
        logic        st, mis, err, done;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        st  = wr;
        mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        ea  = a - (a % 4);
        eb  = m_be(a, sz);
        ew  = m_wd(wd, sz);
        err = 1'b0;
        tick();
        valid_i = 1'b1; rd_en_i = rd; wr_en_i = wr; addr_i = a; wdata_i = wd;
        size_i = sz; ld_unsigned_i = uns; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        if (mis) begin
            push_e(0, 0, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        end else begin
            push_e(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
            done = 1'b0;
            for (int i = 0; !done; i++) begin
                tick();
                dbus_gnt_i = (i == gnt_at);
                // rvalid alongside gnt must be ignored
                dbus_rvalid_i = dbus_gnt_i && !st;
                dbus_rdata_i = 32'h5A5A_5A5A;
                push_e(1, 1, 0, 0, 0, st, ea, eb, ew);
                if (dbus_gnt_i) done = 1'b1;
                else if (i == T - 1) begin done = 1'b1; err = 1'b1; end
            end
            if (!st && !err) begin
                done = 1'b0;
                for (int j = 0; !done; j++) begin
                    tick();
                    dbus_gnt_i = 1'b0;
                    dbus_rvalid_i = (j == rv_at);
                    dbus_rdata_i = rdata;
                    push_e(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
                    if (dbus_rvalid_i) begin
                        m_ld = m_ext(rdata, a, sz, uns); done = 1'b1;
                    end else if (j == T - 1) begin
                        m_ld = 32'h0; err = 1'b1; done = 1'b1;
                    end
                end
            end
            tick();
            dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
            push_e(0, 0, 0, !st && !err, err, 0, 32'h0, 4'h0, 32'h0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_req"}, dbus_req_o, 1'b0);
        chk1({tag, "_stall"}, stall_o, 1'b0);
        chk1({tag, "_mis"}, misalign_o, 1'b0);
        chk1({tag, "_lv"}, load_valid_o, 1'b0);
        chk1({tag, "_err"}, bus_err_o, 1'b0);
        chk1({tag, "_we"}, dbus_we_o, 1'b0);
        chk({tag, "_addr"}, dbus_addr_o, 32'h0);
        chk({tag, "_be"}, {28'b0, dbus_be_o}, 32'h0);
        chk({tag, "_wdata"}, dbus_wdata_o, 32'h0);
        chk({tag, "_ld"}, load_data_o, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; size_i = 2'd0; ld_unsigned_i = 1'b0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        idle_cycle(); idle_cycle();

        // Word store, immediate grant
        req_cnt = 0;
        do_access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 0, 32'h0);
        @(negedge clk);
        chk("lit_st_addr", dbus_addr_o, 32'h0000_0100);
        chk("lit_st_be", {28'b0, dbus_be_o}, 32'hF);
        chk("lit_st_wdata", dbus_wdata_o, 32'hDEAD_BEEF);
        chk1("lit_st_we", dbus_we_o, 1'b1);
        chk("lit_st_reqcnt", req_cnt, 1);
        idle_cycle();

        // Byte load at offset 3, signed then unsigned
        do_access(1'b1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 0, 0, 32'h80FF_0000);
        @(negedge clk);
        chk("lit_lb_data", load_data_o, 32'hFFFF_FF80);
        chk("lit_lb_be", {28'b0, dbus_be_o}, 32'h8);
        idle_cycle();
        do_access(1'b1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 0, 0, 32'h80FF_0000);
        @(negedge clk);
        chk("lit_lbu_data", load_data_o, 32'h0000_0080);
        idle_cycle();

        // Half store, grant on fourth REQ cycle
        req_cnt = 0;
        do_access(1'b0, 1'b1, 32'h12, 32'h1234_ABCD, 2'd1, 1'b0, 3, 0, 32'h0);
        @(negedge clk);
        chk("lit_sh_be", {28'b0, dbus_be_o}, 32'hC);
        chk("lit_sh_wdata", dbus_wdata_o, 32'hABCD_ABCD);
        chk("lit_sh_reqcnt", req_cnt, 4);
        idle_cycle();

        // Misaligned accesses never reach the bus
        req_cnt = 0;
        do_access(1'b1, 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0, 0, 32'h0);
        idle_cycle();
        do_access(1'b1, 1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0);
        idle_cycle();
        do_access(1'b0, 1'b1, 32'h200, 32'h0, 2'd3, 1'b0, 0, 0, 32'h0);
        idle_cycle();
        chk("lit_mis_reqcnt", req_cnt, 0);

        // Signed half at offset 2, rvalid on third RDATA cycle
        do_access(1'b1, 1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0, 2, 32'h8001_7FFF);
        @(negedge clk);
        chk("lit_lh_data", load_data_o, 32'hFFFF_8001);
        idle_cycle();

        // Both enables set: treated as a store
        do_access(1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 2'd2, 1'b0, 1, 0, 32'h0);
        idle_cycle();

        // Load timeout in RDATA, then store timeout in REQ
        do_access(1'b1, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0, 0, -1, 32'h0);
        @(negedge clk);
        chk("lit_to_data", load_data_o, 32'h0);
        idle_cycle();
        do_access(1'b0, 1'b1, 32'h84, 32'h1, 2'd2, 1'b0, -1, 0, 32'h0);
        idle_cycle();

        // Unsigned byte at offset 1
        do_access(1'b1, 1'b0, 32'h301, 32'h0, 2'd0, 1'b1, 0, 0, 32'h1234_5678);
        @(negedge clk);
        chk("lit_lbu1_data", load_data_o, 32'h0000_0056);
        idle_cycle();

        // Reset while waiting in RDATA
        tick();
        valid_i = 1'b1; rd_en_i = 1'b1; wr_en_i = 1'b0; addr_i = 32'h300;
        size_i = 2'd2; ld_unsigned_i = 1'b0;
        push_e(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        dbus_gnt_i = 1'b1;
        push_e(1, 1, 0, 0, 0, 0, 32'h300, 4'hF, 32'h0);
        tick();
        dbus_gnt_i = 1'b0;
        push_e(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        m_ld = 32'h0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        valid_i = 1'b0; rd_en_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        idle_cycle();
        do_access(1'b0, 1'b1, 32'h2, 32'h0000_BEEF, 2'd1, 1'b0, 0, 0, 32'h0);
        @(negedge clk);
        chk("lit_post_be", {28'b0, dbus_be_o}, 32'hC);
        chk("lit_post_wdata", dbus_wdata_o, 32'hBEEF_BEEF);
        idle_cycle(); idle_cycle(); idle_cycle();
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
